alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 102 ++++++++++
 tb/tb_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit registered ALU: eight operations selected by a 3-bit opcode, with the
// result and carry/borrow/shift-out flag captured on enabled clock edges.
module alu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_data_a,
  input  logic [15:0] i_data_b,
  input  logic [2:0]  i_opcode,
  output logic        o_cf,
  output logic [15:0] o_results
);

  localparam logic [2:0] OP_SLT = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [16:0] w_shl;
  logic [16:0] w_shr;
  logic [3:0]  w_shamt;
  logic [15:0] w_result;
  logic        w_cf;
  logic [15:0] r_results;
  logic        r_cf;

  assign w_sum   = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign w_diff  = {1'b0, i_data_a} - {1'b0, i_data_b};
  assign w_shamt = i_data_b[3:0];
  // A guard bit on the exit side of each shift catches the last bit shifted out;
  // a zero shift leaves the guard bit at 0.
  assign w_shl   = {1'b0, i_data_a} << w_shamt;
  assign w_shr   = {i_data_a, 1'b0} >> w_shamt;

  // Next-result and flag selection
  always_comb begin
    w_result = 16'h0000;
    w_cf     = 1'b0;
    case (i_opcode)
      OP_SLT: begin
        w_result = (i_data_a < i_data_b) ? 16'h0001 : 16'h0000;
        w_cf     = 1'b0;
      end
      OP_ADD: begin
        w_result = w_sum[15:0];
        w_cf     = w_sum[16];
      end
      OP_AND: begin
        w_result = i_data_a & i_data_b;
        w_cf     = 1'b0;
      end
      OP_OR: begin
        w_result = i_data_a | i_data_b;
        w_cf     = 1'b0;
      end
      OP_SUB: begin
        w_result = w_diff[15:0];
        w_cf     = w_diff[16];
      end
      OP_XOR: begin
        w_result = i_data_a ^ i_data_b;
        w_cf     = 1'b0;
      end
      OP_SHL: begin
        w_result = w_shl[15:0];
        w_cf     = w_shl[16];
      end
      OP_SHR: begin
        w_result = w_shr[16:1];
        w_cf     = w_shr[0];
      end
      default: begin
        w_result = 16'h0000;
        w_cf     = 1'b0;
      end
    endcase
  end

  // Output registers: async clear, load when enabled, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_results <= 16'h0000;
      r_cf      <= 1'b0;
    end else if (i_enable) begin
      r_results <= w_result;
      r_cf      <= w_cf;
    end else begin
      r_results <= r_results;
      r_cf      <= r_cf;
    end
  end

  assign o_results = r_results;
  assign o_cf      = r_cf;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with fixed expectations, then
// randomized operations checked against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [2:0]  opcode;
  logic        cf;
  logic [15:0] results;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] exp_res = 16'h0000;
  logic        exp_cf  = 1'b0;

  alu dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (enable),
    .i_data_a  (data_a),
    .i_data_b  (data_b),
    .i_opcode  (opcode),
    .o_cf      (cf),
    .o_results (results)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: returns {cf, result} using plain integer arithmetic.
  function automatic logic [16:0] model(input logic [2:0] op, input int unsigned a,
                                        input int unsigned b);
    int unsigned r;
    int unsigned c;
    int unsigned s;
    r = 0;
    c = 0;
    s = b % 16;
    case (op)
      3'd0: r = (a < b) ? 1 : 0;
      3'd1: begin r = (a + b) % 65536; c = (a + b) / 65536; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = (a + 65536 - b) % 65536; c = (a < b) ? 1 : 0; end
      3'd5: r = a ^ b;
      3'd6: begin
        r = (a * (1 << s)) % 65536;
        c = (s == 0) ? 0 : (a / (1 << (16 - s))) % 2;
      end
      default: begin
        r = a / (1 << s);
        c = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2;
      end
    endcase
    return {c[0], r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_mis++;
      $error("FAIL %s: observed cf=%0b res=%h expected cf=%0b res=%h",
             tag, got[16], got[15:0], expv[16], expv[15:0]);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model.
  task automatic step(input logic en, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op);
    logic [16:0] m;
    @(negedge clk);
    enable = en;
    data_a = a;
    data_b = b;
    opcode = op;
    @(posedge clk);
    #1;
    if (en && rst_n) begin
      m = model(op, a, b);
      exp_cf  = m[16];
      exp_res = m[15:0];
    end
  endtask

  task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] want_res,
                          input logic want_cf);
    step(1'b1, a, b, op);
    check(tag, {cf, results}, {want_cf, want_res});
    check({tag, "_model"}, {cf, results}, {exp_cf, exp_res});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  rop;
    logic        ren;
    rst_n  = 1'b1;
    enable = 1'b0;
    data_a = 16'h0000;
    data_b = 16'h0000;
    opcode = 3'b000;

    #2 rst_n = 1'b0;
    #1 check("reset_async", {cf, results}, 17'h0_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h6464, 16'h4646, 3'b001);
      check("enable_low_hold", {cf, results}, 17'h0_0000);
    end

    op_check("add",      16'h6464, 16'h4646, 3'b001, 16'hAAAA, 1'b0);
    op_check("sub",      16'h6464, 16'h4646, 3'b100, 16'h1E1E, 1'b0);
    op_check("add_ovf",  16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b1);
    op_check("sub_brw",  16'h0000, 16'h0001, 3'b100, 16'hFFFF, 1'b1);
    op_check("and",      16'h6464, 16'h4646, 3'b010, 16'h4444, 1'b0);
    op_check("or",       16'h6464, 16'h4646, 3'b011, 16'h6666, 1'b0);
    op_check("xor",      16'h6464, 16'h4646, 3'b101, 16'h2222, 1'b0);
    op_check("slt_ge",   16'h6464, 16'h4646, 3'b000, 16'h0000, 1'b0);
    op_check("slt_lt",   16'h0001, 16'h0002, 3'b000, 16'h0001, 1'b0);
    op_check("slt_eq",   16'h1234, 16'h1234, 3'b000, 16'h0000, 1'b0);
    op_check("shl6",     16'h6464, 16'h4646, 3'b110, 16'h1900, 1'b1);
    op_check("shr6",     16'h6464, 16'h4646, 3'b111, 16'h0191, 1'b1);
    op_check("shl0",     16'h6464, 16'h0000, 3'b110, 16'h6464, 1'b0);
    op_check("shr0",     16'h6464, 16'h0000, 3'b111, 16'h6464, 1'b0);
    op_check("shl15",    16'h0003, 16'hFFFF, 3'b110, 16'h8000, 1'b1);
    op_check("shr15",    16'h8001, 16'h001F, 3'b111, 16'h0001, 1'b0);

    op_check("add_load", 16'h6464, 16'h4646, 3'b001, 16'hAAAA, 1'b0);
    // Changing inputs between edges must not disturb the registered outputs.
    @(negedge clk);
    enable = 1'b0;
    opcode = 3'b010;
    data_a = 16'hFFFF;
    #1 check("between_edges", {cf, results}, 17'h0_AAAA);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0F0F, 16'hF0F0, 3'b010);
      check("hold_and", {cf, results}, 17'h0_AAAA);
    end

    op_check("pre_reset", 16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b1);
    @(negedge clk);
    enable = 1'b1;
    data_a = 16'h1111;
    data_b = 16'h2222;
    opcode = 3'b001;
    #2 rst_n = 1'b0;
    #1 check("reset_mid", {cf, results}, 17'h0_0000);
    @(posedge clk);
    #1 check("reset_held_en", {cf, results}, 17'h0_0000);
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    exp_res = 16'h0000;
    exp_cf  = 1'b0;
    step(1'b0, 16'h1111, 16'h2222, 3'b001);
    check("post_reset_idle", {cf, results}, 17'h0_0000);
    op_check("post_reset_first", 16'h1111, 16'h2222, 3'b001, 16'h3333, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      ren = ($urandom_range(0, 4) != 0);
      if (i % 17 == 0) ra = 16'hFFFF;
      if (i % 23 == 0) rb = 16'h0000;
      step(ren, ra, rb, rop);
      check("random", {cf, results}, {exp_cf, exp_res});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
